// File: rtl/ac_loader_pkg.sv
// rtl/ac_loader_pkg.sv - shared state encoding and parameter defaults for the accumulator loader
package ac_loader_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 10;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_LOAD = 3'd2,
        ST_CLR  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/ac_loader_if.sv
// rtl/ac_loader_if.sv - memory read bus between the loader (master) and the memory (slave)
interface ac_loader_if
    import ac_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/ac_loader.sv
// rtl/ac_loader.sv - command FSM that clears the accumulator or loads it from memory with an ack timeout
module ac_loader
    import ac_loader_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic              op_clr,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    ac_loader_if.master       mem,
    output logic [DATA_W-1:0] ac_in,
    output logic              ac_re,
    output logic              ac_clear
);

    // The counter must be able to hold TIMEOUT itself; the abort decision is
    // taken in the REQ cycle whose increment would make it reach TIMEOUT.
    localparam int              CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Single FSM: every output is computed for the next state and registered,
    // so pulses line up with the state they belong to. ac_in doubles as the
    // capture register for mem_rdata and therefore holds outside LOAD.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            ac_in        <= '0;
            ac_re        <= 1'b0;
            ac_clear     <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            ac_re    <= 1'b0;
            ac_clear <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (op_clr) begin
                            state    <= ST_CLR;
                            ac_clear <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            state        <= ST_REQ;
                            mem.mem_addr <= addr;
                            mem.mem_req  <= 1'b1;
                            wait_cnt     <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        // An ack in the final permitted cycle still completes the load.
                        state       <= ST_LOAD;
                        ac_in       <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        ac_re       <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == LIMIT) begin
                            state       <= ST_ERR;
                            mem.mem_req <= 1'b0;
                            err         <= 1'b1;
                        end
                    end
                end
                ST_LOAD, ST_CLR, ST_ERR: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ac_loader.sv
// tb/tb_ac_loader.sv - scoreboard bench for ac_loader with directed command sequences
module tb_ac_loader;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 10;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic              done;
        logic              err;
        logic              ac_re;
        logic              ac_clear;
        logic [DATA_W-1:0] ac_in;
    } ev_t;

    logic              clk;
    logic              clear_n;
    logic              start;
    logic              op_clr;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] ac_in;
    logic              ac_re;
    logic              ac_clear;

    ac_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    ac_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .start    (start),
        .op_clr   (op_clr),
        .addr     (addr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem      (mem_bus),
        .ac_in    (ac_in),
        .ac_re    (ac_re),
        .ac_clear (ac_clear)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    ev_t  exp_q[$];
    int   exp_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk = n_chk + 1;
        if (act === req) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input ev_t ev, input int at);
        exp_q.push_back(ev);
        exp_cyc.push_back(at);
    endtask

    // Monitor: any pulse on done/err/ac_re/ac_clear must match the oldest expectation.
    initial begin
        ev_t act;
        ev_t req;
        int  req_c;
        forever begin
            @(negedge clk);
            if (done || err || ac_re || ac_clear) begin
                act = '{done: done, err: err, ac_re: ac_re, ac_clear: ac_clear,
                        ac_in: (ac_re ? ac_in : '0)};
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {32'(act), 32'(cyc)}, 64'd0);
                end else begin
                    req   = exp_q.pop_front();
                    req_c = exp_cyc.pop_front();
                    chk("pulse_event", {32'(act), 32'(cyc)}, {32'(req), 32'(req_c)});
                end
            end
        end
    end

    task automatic do_clear();
        int c0;
        step();
        start = 1'b1; op_clr = 1'b1;
        c0 = cyc;
        push('{done: 1'b1, err: 1'b0, ac_re: 1'b0, ac_clear: 1'b1, ac_in: '0}, c0 + 1);
        step();
        start = 1'b0;
        chk("clr_busy", 64'(busy), 64'd1);
        chk("clr_no_req", 64'(mem_bus.mem_req), 64'd0);
        step();
        chk("clr_no_req_after", 64'(mem_bus.mem_req), 64'd0);
        chk("clr_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int delay, input bit poke);
        int c0;
        int k;
        step();
        start = 1'b1; op_clr = 1'b0; addr = a;
        c0 = cyc;
        k = c0 + delay;
        step();
        start = 1'b0;
        addr  = ~a;
        chk("ld_req", 64'(mem_bus.mem_req), 64'd1);
        chk("ld_addr", 64'(mem_bus.mem_addr), 64'(a));
        while (cyc < k) begin
            step();
            start  = poke && (cyc == c0 + 2);
            op_clr = 1'b1;
        end
        start = 1'b0;
        op_clr = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = d;
        push('{done: 1'b1, err: 1'b0, ac_re: 1'b1, ac_clear: 1'b0, ac_in: d}, k + 1);
        step();
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        chk("ld_req_drop", 64'(mem_bus.mem_req), 64'd0);
        step();
        chk("ld_idle", 64'(busy), 64'd0);
        chk("ld_ac_hold", 64'(ac_in), 64'(d));
    endtask

    initial begin
        int c0;
        clear_n = 1'b0;
        start   = 1'b0;
        op_clr  = 1'b0;
        addr    = '0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        #3;
        chk("reset_outputs",
            64'({busy, done, err, mem_bus.mem_req, ac_re, ac_clear, mem_bus.mem_addr, ac_in}), 64'd0);
        step(); step();
        clear_n = 1'b1;

        do_clear();
        do_load(8'h2A, 10'h3FF, 3, 1'b0);

        // Stray ack in IDLE must not disturb anything.
        step();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 10'h155;
        step(); step();
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        step();
        chk("stray_ack_idle", 64'({busy, mem_bus.mem_req}), 64'd0);
        chk("stray_ack_hold", 64'(ac_in), 64'h3FF);

        // A start pulse during the load must be dropped.
        do_load(8'h10, 10'h123, 5, 1'b1);

        // Timeout without any ack.
        step();
        start = 1'b1; op_clr = 1'b0; addr = 8'h33;
        c0 = cyc;
        push('{done: 1'b0, err: 1'b1, ac_re: 1'b0, ac_clear: 1'b0, ac_in: '0}, c0 + TIMEOUT + 1);
        step();
        start = 1'b0;
        while (cyc < c0 + TIMEOUT) step();
        chk("to_still_req", 64'({busy, mem_bus.mem_req}), 64'd3);
        while (cyc < c0 + TIMEOUT + 2) step();
        chk("to_idle", 64'({busy, mem_bus.mem_req}), 64'd0);
        chk("to_ac_hold", 64'(ac_in), 64'h123);

        // Ack in the last allowed REQ cycle.
        do_load(8'h77, 10'h0AB, TIMEOUT, 1'b0);

        // Reset during REQ.
        step();
        start = 1'b1; op_clr = 1'b0; addr = 8'h44;
        step();
        start = 1'b0;
        step(); step();
        clear_n = 1'b0;
        #1;
        chk("midreset_outputs",
            64'({busy, done, err, mem_bus.mem_req, ac_re, ac_clear, mem_bus.mem_addr, ac_in}), 64'd0);
        step(); step();
        clear_n = 1'b1;
        do_load(8'h05, 10'h201, 2, 1'b0);
        chk("after_reset_addr", 64'(mem_bus.mem_addr), 64'h05);

        repeat (4) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
